// File: rtl/multiplicacion_secuencial_if.sv
//------------------------------------------------------------------------------
// Module   : multiplicacion_secuencial_if
// Brief    : Start/busy/done bus of the sequential multiplier. Adds desborde when
//            MULT_DESBORDE_EN is defined.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface multiplicacion_secuencial_if #(
   parameter int M = 4
);
   logic             inicio;
   logic [M-1:0]     multiplicando;
   logic [M-1:0]     multiplicador;
   logic [2*M-1:0]   producto;
   logic             ocupado;
   logic             listo;
`ifdef MULT_DESBORDE_EN
   logic             desborde;

   modport master (
      output inicio, multiplicando, multiplicador,
      input  producto, ocupado, listo, desborde
   );
   modport slave (
      input  inicio, multiplicando, multiplicador,
      output producto, ocupado, listo, desborde
   );
`else
   modport master (
      output inicio, multiplicando, multiplicador,
      input  producto, ocupado, listo
   );
   modport slave (
      input  inicio, multiplicando, multiplicador,
      output producto, ocupado, listo
   );
`endif
endinterface

`default_nettype wire

// File: rtl/multiplicacion_secuencial.sv
//------------------------------------------------------------------------------
// Module   : multiplicacion_secuencial
// Brief    : Unsigned shift-and-add multiplier, M iterations per product.
//            Optional overflow flag enabled by macro MULT_DESBORDE_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module multiplicacion_secuencial #(
   parameter int M = 4
) (
   input  wire logic                   clk,
   input  wire logic                   rst_n,
   multiplicacion_secuencial_if.slave  bus_if
);

   localparam int c_cnt_w = $clog2(M + 1);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      CALC = 1'b1
   } state_t;

   state_t              state_q;
   logic [M-1:0]        mcand_q;
   logic [2*M:0]        shift_q;      // {carry, accumulator, multiplier}
   logic [c_cnt_w-1:0]  cnt_q;
   logic [2*M-1:0]      producto_q;
   logic                ocupado_q;
   logic                listo_q;
`ifdef MULT_DESBORDE_EN
   logic                desborde_q;
`endif

   logic [M:0]          w_upper;
   logic [2*M:0]        w_shift_next;

   // Add is M+1 bits wide so the carry survives into the shift
   always_comb begin
      w_upper = shift_q[2*M:M];
      if (shift_q[0]) begin
         w_upper = shift_q[2*M:M] + {1'b0, mcand_q};
      end
      w_shift_next = {1'b0, w_upper, shift_q[M-1:1]};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         mcand_q    <= '0;
         shift_q    <= '0;
         cnt_q      <= '0;
         producto_q <= '0;
         ocupado_q  <= 1'b0;
         listo_q    <= 1'b0;
`ifdef MULT_DESBORDE_EN
         desborde_q <= 1'b0;
`endif
      end else begin
         listo_q <= 1'b0;
         case (state_q)
            IDLE: begin
               ocupado_q <= 1'b0;
               if (bus_if.inicio) begin
                  mcand_q   <= bus_if.multiplicando;
                  shift_q   <= {{(M+1){1'b0}}, bus_if.multiplicador};
                  cnt_q     <= '0;
                  ocupado_q <= 1'b1;
                  state_q   <= CALC;
               end
            end
            CALC: begin
               shift_q <= w_shift_next;
               cnt_q   <= cnt_q + c_cnt_w'(1);
               if (cnt_q == c_cnt_w'(M - 1)) begin
                  producto_q <= w_shift_next[2*M-1:0];
`ifdef MULT_DESBORDE_EN
                  desborde_q <= |w_shift_next[2*M-1:M];
`endif
                  listo_q    <= 1'b1;
                  ocupado_q  <= 1'b0;
                  state_q    <= IDLE;
               end
            end
            default: begin
               state_q   <= IDLE;
               ocupado_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus_if.producto = producto_q;
   assign bus_if.ocupado  = ocupado_q;
   assign bus_if.listo    = listo_q;
`ifdef MULT_DESBORDE_EN
   assign bus_if.desborde = desborde_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_multiplicacion_secuencial.sv
//------------------------------------------------------------------------------
// Module   : tb_multiplicacion_secuencial
// Brief    : Scoreboard bench for the sequential multiplier (M = 4).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_multiplicacion_secuencial;

   localparam int M = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   multiplicacion_secuencial_if #(.M(M)) bus ();

   multiplicacion_secuencial #(.M(M)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .bus_if (bus)
   );

   typedef struct packed {
      logic [7:0] prod;
      logic       desb;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   checks      = 0;
   int   errors      = 0;
   int   listo_count = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every listo pulse consumes one scoreboard entry
   always @(negedge clk) begin
      if (rst_n && bus.listo === 1'b1) begin
         listo_count++;
         if (sb.size() == 0) begin
            chk("listo_unexpected", sb.size(), 1);
         end else begin
            mon_e = sb.pop_front();
            chk("producto", {24'd0, bus.producto}, {24'd0, mon_e.prod});
`ifdef MULT_DESBORDE_EN
            chk("desborde", {31'd0, bus.desborde}, {31'd0, mon_e.desb});
`endif
            chk("ocupado_at_listo", {31'd0, bus.ocupado}, 32'd0);
         end
      end
   end

   task automatic run_op(input logic [3:0] a, input logic [3:0] b,
                         input logic [7:0] p, input logic d, input string name);
      int n;
      bit seen;
      @(negedge clk);
      bus.inicio        = 1'b1;
      bus.multiplicando = a;
      bus.multiplicador = b;
      sb.push_back('{p, d});
      seen = 0;
      n    = 0;
      for (int i = 1; i <= 20 && !seen; i++) begin
         @(negedge clk);
         bus.inicio = 1'b0;
         n = i;
         if (bus.listo) seen = 1;
         else if (i <= M) chk({name, "_ocupado"}, {31'd0, bus.ocupado}, 32'd1);
      end
      chk({name, "_latency"}, n, M + 1);
   endtask

   initial begin
      int  n1, n2, lc;
      bit  seen;

      bus.inicio        = 1'b0;
      bus.multiplicando = '0;
      bus.multiplicador = '0;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_producto", {24'd0, bus.producto}, 32'd0);
      chk("rst_ocupado",  {31'd0, bus.ocupado},  32'd0);
      chk("rst_listo",    {31'd0, bus.listo},    32'd0);
`ifdef MULT_DESBORDE_EN
      chk("rst_desborde", {31'd0, bus.desborde}, 32'd0);
`endif
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("idle_producto", {24'd0, bus.producto}, 32'd0);
      chk("idle_ocupado",  {31'd0, bus.ocupado},  32'd0);
      chk("idle_listo_count", listo_count, 0);

      run_op(4'hF, 4'hF, 8'hE1, 1'b1, "max");
      run_op(4'h3, 4'h5, 8'h0F, 1'b0, "small");
      run_op(4'h7, 4'h0, 8'h00, 1'b0, "b_zero");
      run_op(4'h0, 4'h9, 8'h00, 1'b0, "a_zero");

      // Start request while busy must be ignored
      @(negedge clk);
      bus.inicio = 1'b1; bus.multiplicando = 4'h6; bus.multiplicador = 4'h7;
      sb.push_back('{8'h2A, 1'b1});
      lc = listo_count;
      seen = 0; n1 = 0;
      for (int i = 1; i <= 20 && !seen; i++) begin
         @(negedge clk);
         n1 = i;
         if (i == 2) begin
            bus.inicio = 1'b1; bus.multiplicando = 4'h2; bus.multiplicador = 4'h2;
         end else begin
            bus.inicio = 1'b0;
         end
         if (bus.listo) seen = 1;
      end
      chk("ignored_latency", n1, M + 1);
      repeat (8) @(negedge clk);
      chk("ignored_single_listo", listo_count - lc, 1);
      chk("ignored_hold", {24'd0, bus.producto}, 32'h2A);

      // Back-to-back with inicio held high
      @(negedge clk);
      bus.inicio = 1'b1; bus.multiplicando = 4'hC; bus.multiplicador = 4'hA;
      sb.push_back('{8'h78, 1'b1});
      sb.push_back('{8'h01, 1'b0});
      seen = 0; n1 = 0;
      for (int i = 1; i <= 20 && !seen; i++) begin
         @(negedge clk);
         n1 = i;
         if (i == 1) begin
            bus.multiplicando = 4'h1; bus.multiplicador = 4'h1;
         end
         if (bus.listo) seen = 1;
      end
      chk("b2b_first_latency", n1, M + 1);
      seen = 0; n2 = 0;
      for (int j = 1; j <= 20 && !seen; j++) begin
         @(negedge clk);
         n2 = j;
         if (j == 1) bus.inicio = 1'b0;
         if (bus.listo) seen = 1;
         else chk("b2b_stable", {24'd0, bus.producto}, 32'h78);
      end
      chk("b2b_gap", n2, M + 1);

      // Reset in the middle of an operation
      @(negedge clk);
      bus.inicio = 1'b1; bus.multiplicando = 4'h9; bus.multiplicador = 4'h9;
      @(negedge clk);
      bus.inicio = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst_producto", {24'd0, bus.producto}, 32'd0);
      chk("midrst_ocupado",  {31'd0, bus.ocupado},  32'd0);
      chk("midrst_listo",    {31'd0, bus.listo},    32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      lc = listo_count;
      repeat (8) @(negedge clk);
      chk("midrst_no_listo", listo_count - lc, 0);
      run_op(4'h2, 4'h3, 8'h06, 1'b0, "after_rst");

      repeat (2) @(negedge clk);
      chk("sb_drained", sb.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire
